// File: rtl/spi_ram_master.sv
// Host-side SPI sequencer: turns one write/read request into an address frame plus a
// data frame for the SPI RAM slave, and captures the read byte from MISO.
module spi_ram_master #(
    parameter int RD_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEL, S_SHIFT, S_GAP, S_RD_WAIT, S_RD_CAP, S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 2);

    state_t     state_q, state_d;
    logic       rd_q, rd_d;
    logic       frame2_q, frame2_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [9:0] sh_q, sh_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] cap_q, cap_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       done_q, done_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;

    // Outputs are computed for the state being entered, so they are registered in step with it.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        frame2_d    = frame2_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        ss_n_d      = ss_n_q;
        mosi_d      = 1'b0;
        cmd_ready_d = 1'b0;
        done_d      = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                ss_n_d      = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = S_START;
                    rd_d        = cmd_rd;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    frame2_d    = 1'b0;
                    cmd_ready_d = 1'b0;
                    ss_n_d      = 1'b0;
                end
            end
            S_START: begin
                state_d = S_SEL;
                mosi_d  = rd_q;
                sh_d    = {rd_q, frame2_q, frame2_q ? (rd_q ? 8'h00 : wdata_q) : addr_q};
            end
            S_SEL: begin
                state_d = S_SHIFT;
                mosi_d  = sh_q[9];
                sh_d    = {sh_q[8:0], 1'b0};
                cnt_d   = 4'd9;
            end
            S_SHIFT: begin
                if (cnt_q != 4'd0) begin
                    mosi_d = sh_q[9];
                    sh_d   = {sh_q[8:0], 1'b0};
                    cnt_d  = cnt_q - 4'd1;
                end else if (!frame2_q) begin
                    state_d  = S_GAP;
                    ss_n_d   = 1'b1;
                    frame2_d = 1'b1;
                end else if (!rd_q) begin
                    state_d     = S_DONE;
                    ss_n_d      = 1'b1;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                end else if (RD_LAT == 1) begin
                    state_d = S_RD_CAP;
                    cnt_d   = 4'd7;
                end else begin
                    state_d = S_RD_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_GAP: begin
                state_d = S_START;
                ss_n_d  = 1'b0;
            end
            S_RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RD_CAP;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD_CAP: begin
                cap_d = {cap_q[6:0], MISO};
                if (cnt_q == 4'd0) begin
                    state_d     = S_DONE;
                    ss_n_d      = 1'b1;
                    done_d      = 1'b1;
                    rd_valid_d  = 1'b1;
                    cmd_ready_d = 1'b1;
                    rd_data_d   = {cap_q[6:0], MISO};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                ss_n_d      = 1'b1;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_q        <= 1'b0;
            frame2_q    <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            sh_q        <= 10'h000;
            cnt_q       <= 4'd0;
            cap_q       <= 8'h00;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            frame2_q    <= frame2_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with a behavioural SPI RAM slave that decodes frames
// from SS_n/MOSI and returns read data on MISO RD_LAT cycles after the read-data frame.
module tb_spi_ram_master;
    localparam int RD_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rd = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, done, rd_valid, ss_n, mosi;
    logic [7:0] rd_data;
    logic       miso;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_ram_master #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
        .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    // Slave model: everything observed mid-cycle on the falling edge.
    logic [7:0] ram [0:255];
    logic [7:0] s_addr;
    logic [7:0] s_rdata;
    logic [9:0] s_sh;
    int         s_idx;
    int         s_n;
    bit         s_pend;
    int         done_cnt;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst) begin
            s_idx  = 0;
            s_pend = 0;
            miso   = 1'b0;
        end else begin
            if (s_pend) begin
                s_n++;
                if (s_n >= RD_LAT && s_n < RD_LAT + 8) begin
                    miso = s_rdata[7 - (s_n - RD_LAT)];
                end else if (s_n >= RD_LAT + 8) begin
                    s_pend = 0;
                    miso   = 1'b0;
                end
            end
            if (ss_n) begin
                s_idx = 0;
            end else begin
                if (s_idx >= 2) s_sh = {s_sh[8:0], mosi};
                if (s_idx == 11) begin
                    case (s_sh[9:8])
                        2'b00: s_addr = s_sh[7:0];
                        2'b01: ram[s_addr] = s_sh[7:0];
                        2'b10: s_addr = s_sh[7:0];
                        default: begin
                            s_rdata = ram[s_addr];
                            s_pend  = 1;
                            s_n     = 0;
                        end
                    endcase
                end
                s_idx++;
            end
        end
    end

    logic ss_hist   [0:63];
    logic mosi_hist [0:63];
    logic rdy_hist  [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] hist_frame(input int first);
        logic [10:0] f = '0;
        for (int i = 0; i < 11; i++) f = {f[9:0], mosi_hist[first + i]};
        return f;
    endfunction

    // Issue one request starting at a falling edge; cycle c of the history is Cc after accept.
    task automatic run_cmd(input logic rd, input logic [7:0] a, input logic [7:0] wd,
                           input bit hold, input int pulse_at, input int rst_at,
                           output int lat, output int wait_n);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        wait_n    = 0;
        lat       = -1;
        while (!cmd_ready && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        for (int c = 1; c < 64; c++) begin
            @(negedge clk);
            ss_hist[c]   = ss_n;
            mosi_hist[c] = mosi;
            rdy_hist[c]  = cmd_ready;
            if (c == pulse_at) begin
                cmd_valid = 1'b1;
                cmd_addr  = 8'h77;
                cmd_wdata = 8'h11;
            end
            if (c == pulse_at + 1) begin
                cmd_valid = 1'b0;
                cmd_addr  = a;
                cmd_wdata = wd;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_ss_n_async", 32'(ss_n), 32'd1);
                check("rst_mosi_async", 32'(mosi), 32'd0);
                check("rst_ready_async", 32'(cmd_ready), 32'd1);
                lat = -2;
                break;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat, wn, dc;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[3] = 8'hB2;

        repeat (3) @(negedge clk);
        check("in_reset_ss_n", 32'(ss_n), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ss_n", 32'(ss_n), 32'd1);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_rd_data", 32'(rd_data), 32'h00);
        check("reset_done", 32'({done, rd_valid}), 32'd0);

        // Write 0xAA to 0xFF
        run_cmd(1'b0, 8'hFF, 8'hAA, 1'b0, -1, -1, lat, wn);
        check("wr_latency", 32'(lat), 32'd26);
        check("wr_start_c1", 32'({ss_hist[1], mosi_hist[1]}), 32'b00);
        check("wr_frame1", 32'(hist_frame(2)), 32'b0_00_11111111);
        check("wr_gap_ss_n", 32'(ss_hist[13]), 32'd1);
        check("wr_start2", 32'({ss_hist[14], mosi_hist[14]}), 32'b00);
        check("wr_frame2", 32'(hist_frame(15)), 32'b0_01_10101010);
        check("wr_done_flags", 32'({ss_n, cmd_ready, rd_valid}), 32'b110);
        check("wr_ram", 32'(ram[8'hFF]), 32'hAA);
        @(negedge clk);
        check("wr_done_pulse", 32'(done), 32'd0);

        // Read 0x03 (slave preloaded with 0xB2)
        run_cmd(1'b1, 8'h03, 8'h00, 1'b0, -1, -1, lat, wn);
        check("rd_latency", 32'(lat), 32'd36);
        check("rd_frame1", 32'(hist_frame(2)), 32'b1_10_00000011);
        check("rd_gap_ss_n", 32'(ss_hist[13]), 32'd1);
        check("rd_frame2", 32'(hist_frame(15)), 32'b1_11_00000000);
        check("rd_wait_ss_n", 32'({ss_hist[26], ss_hist[27], ss_hist[35]}), 32'b000);
        check("rd_valid", 32'({rd_valid, ss_n}), 32'b11);
        check("rd_data", 32'(rd_data), 32'hB2);
        @(negedge clk);
        check("rd_pulse_end", 32'({done, rd_valid}), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'hB2);

        // Back-to-back write then read of the same address
        run_cmd(1'b0, 8'h40, 8'h3C, 1'b1, -1, -1, lat, wn);
        check("b2b_wr_latency", 32'(lat), 32'd26);
        check("b2b_wr_ss_n_done", 32'(ss_n), 32'd1);
        run_cmd(1'b1, 8'h40, 8'h00, 1'b0, -1, -1, lat, wn);
        check("b2b_accept_e26", 32'(wn), 32'd0);
        check("b2b_rd_ss_n_c1", 32'(ss_hist[1]), 32'd0);
        check("b2b_rd_frame1", 32'(hist_frame(2)), 32'b1_10_01000000);
        check("b2b_rd_latency", 32'(lat), 32'd36);
        check("b2b_rd_data", 32'(rd_data), 32'h3C);

        // Busy ignore: stray request with another address during a write
        @(negedge clk);
        run_cmd(1'b0, 8'h10, 8'h5C, 1'b0, 8, -1, lat, wn);
        check("busy_ready_c8", 32'(rdy_hist[8]), 32'd0);
        check("busy_latency", 32'(lat), 32'd26);
        check("busy_frame1", 32'(hist_frame(2)), 32'b0_00_00010000);
        check("busy_frame2", 32'(hist_frame(15)), 32'b0_01_01011100);
        check("busy_ram", 32'(ram[8'h10]), 32'h5C);
        check("busy_ram_stray", 32'(ram[8'h77]), 32'h00);
        check("busy_rd_data_hold", 32'(rd_data), 32'h3C);
        repeat (3) @(negedge clk);
        check("busy_no_requeue", 32'({ss_n, cmd_ready}), 32'b11);

        // Reset in C20 of a read
        dc = done_cnt;
        run_cmd(1'b1, 8'h03, 8'h00, 1'b0, -1, 20, lat, wn);
        check("rst_ss_low_before", 32'(ss_hist[20]), 32'd0);
        check("rst_abort", 32'(lat), 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_done", 32'(done_cnt), 32'(dc));
        check("rst_idle", 32'({ss_n, cmd_ready}), 32'b11);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        run_cmd(1'b1, 8'h03, 8'h00, 1'b0, -1, -1, lat, wn);
        check("post_rst_latency", 32'(lat), 32'd36);
        check("post_rst_rd_data", 32'(rd_data), 32'hB2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
